regfile_2r1w: RTL



---
 rtl/regfile_2r1w.sv | 78 +++++++
 1 files changed

// File: rtl/regfile_2r1w.sv
// DEPTH x WIDTH register file: one synchronous byte-enabled write port, two combinational read ports.
// Optional same-cycle write-to-read bypass and hardwired-zero entry 0; async active-high reset clears all entries.
module regfile_2r1w #(
    parameter  int WIDTH    = 32,
    parameter  int DEPTH    = 32,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [WIDTH/8-1:0] wr_be,
    input  logic [AW-1:0]      rd_addr_a,
    output logic [WIDTH-1:0]   rd_data_a,
    input  logic [AW-1:0]      rd_addr_b,
    output logic [WIDTH-1:0]   rd_data_b
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] wr_mask;
    logic             wr_ok;

    // Out-of-range addresses and the hardwired zero entry are neither stored nor readable.
    function automatic logic addr_ok(input logic [AW-1:0] addr);
        return (32'(addr) < 32'(DEPTH)) && !(ZERO_REG != 0 && addr == '0);
    endfunction

    assign wr_ok = wr_en && !reset && addr_ok(wr_addr);

    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < NB; b++) begin
            wr_mask[8*b +: 8] = {8{wr_be[b]}};
        end
    end

    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            for (int b = 0; b < NB; b++) begin
                mem_d[e][8*b +: 8] = (wr_ok && wr_addr == AW'(e) && wr_be[b]) ?
                                     wr_data[8*b +: 8] : mem_q[e][8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Bypassed lanes come from wr_data; the rest from storage. Reset forces zero even over bypass.
    function automatic logic [WIDTH-1:0] read_word(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] word;
        word = '0;
        if (!reset && addr_ok(addr)) begin
            word = mem_q[addr];
            if (BYPASS != 0 && wr_ok && addr == wr_addr) begin
                word = (word & ~wr_mask) | (wr_data & wr_mask);
            end
        end
        return word;
    endfunction

    always_comb begin
        rd_data_a = read_word(rd_addr_a);
        rd_data_b = read_word(rd_addr_b);
    end

endmodule
